// File: rtl/topk_pkg.sv
// Shared definitions for the top-k serial output stage that follows the 16-wide sorters.
package topk_pkg;

  localparam int unsigned TOPK_DATAWIDTH  = 8;
  localparam int unsigned TOPK_DATALENGTH = 16;

  typedef logic [TOPK_DATAWIDTH-1:0] elent;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/topk_stream_out.sv
// Buffers the top K elements of a sorted vector and streams them out largest first,
// one per cycle, over valid/ready; a new vector may be taken on the last transfer.
module topk_stream_out
  import topk_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = TOPK_DATAWIDTH,
  parameter int unsigned DATALENGTH = TOPK_DATALENGTH,
  parameter int unsigned K          = 4,
  localparam int unsigned RW        = (K > 1) ? $clog2(K) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            vec_valid_i,
  output logic                            vec_ready_o,
  input  logic                            sign_ctrl_i,
  input  logic [DATALENGTH*DATAWIDTH-1:0] vec_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATAWIDTH-1:0]            out_data_o,
  output logic [RW-1:0]                   out_rank_o,
  output logic                            out_last_o,
  output logic                            out_sign_o
);

  if (K < 1 || K > DATALENGTH) begin : g_bad_k
    $error("topk_stream_out: K must lie in 1..DATALENGTH");
  end

  localparam logic [RW-1:0] LAST = RW'(K - 1);

  state_t               state, state_nxt;
  logic [RW-1:0]        cnt;
  logic [DATAWIDTH-1:0] buffer [K];
  logic                 sign_q;
  logic                 at_last;
  logic                 accept;
  logic                 advance;

  always_comb begin
    state_nxt   = state;
    vec_ready_o = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    at_last     = (cnt == LAST);
    case (state)
      IDLE: begin
        vec_ready_o = !rst_i;
        accept      = vec_valid_i && !rst_i;
        if (accept) state_nxt = EMIT;
      end
      EMIT: begin
        if (out_ready_i) begin
          if (at_last) begin
            // last transfer doubles as an accept slot so back-to-back vectors have no bubble
            vec_ready_o = !rst_i;
            accept      = vec_valid_i && !rst_i;
            state_nxt   = accept ? EMIT : IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      sign_q <= 1'b0;
      for (int unsigned r = 0; r < K; r++) buffer[r] <= '0;
    end else if (accept) begin
      cnt    <= '0;
      sign_q <= sign_ctrl_i;
      // rank 0 is the largest element, which sits at the top index of the input
      for (int unsigned r = 0; r < K; r++)
        buffer[r] <= vec_i[(DATALENGTH - 1 - r) * DATAWIDTH +: DATAWIDTH];
    end else if (advance) begin
      cnt <= cnt + 1'b1;
    end else if (state_nxt == IDLE) begin
      cnt <= '0;
    end
  end

  assign out_valid_o = (state == EMIT);
  assign out_data_o  = buffer[cnt];
  assign out_rank_o  = cnt;
  assign out_last_o  = out_valid_o && at_last;
  assign out_sign_o  = sign_q;

endmodule

// File: tb/tb_topk_stream_out.sv
// Directed check of topk_stream_out: a K=4 instance driven from a vector table and a K=1 instance.
module tb_topk_stream_out;

  logic         clk = 1'b0;
  logic         rst;
  logic         vv, vr, sgn, ov, ordy, ol, os;
  logic [127:0] vec;
  logic [7:0]   od;
  logic [1:0]   orank;

  logic         vv1, vr1, sgn1, ov1, ol1, os1;
  logic [127:0] vec1;
  logic [7:0]   od1;
  logic [0:0]   orank1;

  always #5 clk = ~clk;

  topk_stream_out #(.DATAWIDTH(8), .DATALENGTH(16), .K(4)) dut (
    .clk_i(clk), .rst_i(rst), .vec_valid_i(vv), .vec_ready_o(vr), .sign_ctrl_i(sgn),
    .vec_i(vec), .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od),
    .out_rank_o(orank), .out_last_o(ol), .out_sign_o(os)
  );

  topk_stream_out #(.DATAWIDTH(8), .DATALENGTH(16), .K(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .vec_valid_i(vv1), .vec_ready_o(vr1), .sign_ctrl_i(sgn1),
    .vec_i(vec1), .out_valid_o(ov1), .out_ready_i(1'b1), .out_data_o(od1),
    .out_rank_o(orank1), .out_last_o(ol1), .out_sign_o(os1)
  );

  typedef struct {
    logic rst, vv, sign, ordy;
    int   sel;
    logic full;
    logic ev;
    int   ed, er;
    logic el, es, evr;
  } row_t;

  row_t         rows[$];
  logic [127:0] vecs [3];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input int sel, input logic s, input logic rdy,
                     input logic full, input logic ev, input int ed, input int er,
                     input logic el, input logic es, input logic evr);
    row_t t;
    t.rst = r; t.vv = v; t.sel = sel; t.sign = s; t.ordy = rdy;
    t.full = full; t.ev = ev; t.ed = ed; t.er = er; t.el = el; t.es = es; t.evr = evr;
    rows.push_back(t);
  endtask

  initial begin
    int e0[16] = '{0, 3, 5, 8, 9, 10, 12, 14, 18, 20, 23, 35, 40, 60, 90, 95};
    int ea[16] = '{-100, -90, -80, -70, -60, -50, -40, -30, -20, -10, -5, 0, 5, 10, 25, 35};
    int k1_sel[4]  = '{0, 1, 2, 0};
    int k1_max[3]  = '{95, 35, 15};
    logic k1_sg[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) begin
      vecs[0][i*8 +: 8] = 8'(e0[i]);
      vecs[1][i*8 +: 8] = 8'(ea[i]);
      vecs[2][i*8 +: 8] = 8'(i);
    end

    //   rst vv sel sg rdy  full ev  data rk last sg  vrdy
    add(1, 1, 0, 0, 1,  1, 0,  0, 0, 0, 0, 0);   // reset state, vector ignored
    add(0, 1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 1);   // basic unsigned accept
    add(0, 0, 0, 0, 1,  1, 1, 95, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 90, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 60, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 40, 3, 1, 0, 1);
    add(0, 1, 1, 1, 1,  0, 0,  0, 0, 0, 0, 1);   // signed A
    add(0, 1, 2, 0, 1,  1, 1, 35, 0, 0, 1, 0);
    add(0, 1, 2, 0, 1,  1, 1, 25, 1, 0, 1, 0);
    add(0, 1, 2, 0, 1,  1, 1, 10, 2, 0, 1, 0);
    add(0, 1, 2, 0, 1,  1, 1,  5, 3, 1, 1, 1);   // B taken on A's last
    add(0, 0, 0, 0, 1,  1, 1, 15, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 14, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 13, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 12, 3, 1, 0, 1);
    add(0, 1, 1, 1, 1,  0, 0,  0, 0, 0, 0, 1);   // back-pressure run
    add(0, 0, 0, 0, 1,  1, 1, 35, 0, 0, 1, 0);
    add(0, 1, 2, 0, 0,  1, 1, 25, 1, 0, 1, 0);
    add(0, 1, 2, 0, 0,  1, 1, 25, 1, 0, 1, 0);
    add(0, 1, 2, 0, 0,  1, 1, 25, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1,  1, 1, 25, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1,  1, 1, 10, 2, 0, 1, 0);
    add(0, 0, 0, 0, 1,  1, 1,  5, 3, 1, 1, 1);
    add(0, 1, 1, 1, 1,  0, 0,  0, 0, 0, 0, 1);   // reset mid-stream
    add(0, 0, 0, 0, 1,  1, 1, 35, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1,  1, 1, 25, 1, 0, 1, 0);
    add(1, 1, 2, 0, 1,  1, 1, 10, 2, 0, 1, 0);
    add(0, 0, 0, 0, 1,  1, 0,  0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0,  0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1);   // idle accept, ready low
    add(0, 0, 0, 0, 0,  1, 1, 95, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 95, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 95, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 90, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 60, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, 40, 3, 1, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0,  0, 0, 0, 0, 1);

    rst = 1'b1; vv = 1'b0; sgn = 1'b0; ordy = 1'b0; vec = '0;
    vv1 = 1'b0; sgn1 = 1'b0; vec1 = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      rst = rows[i].rst; vv = rows[i].vv; sgn = rows[i].sign; ordy = rows[i].ordy;
      vec = vecs[rows[i].sel];
      #1;
      chk("out_valid", i, int'(ov), int'(rows[i].ev));
      chk("vec_ready", i, int'(vr), int'(rows[i].evr));
      if (rows[i].full || rows[i].ev) begin
        chk("out_data", i, int'(od), rows[i].ed);
        chk("out_rank", i, int'(orank), rows[i].er);
        chk("out_last", i, int'(ol), int'(rows[i].el));
        chk("out_sign", i, int'(os), int'(rows[i].es));
      end
    end

    // K=1 instance: a new vector every cycle, each emitting its maximum the next cycle
    vv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vv1 = (i < 4);
      if (i < 4) begin
        vec1 = vecs[k1_sel[i]];
        sgn1 = k1_sg[k1_sel[i]];
      end
      #1;
      chk("k1_vec_ready", i, int'(vr1), 1);
      if (i > 0) begin
        chk("k1_out_valid", i, int'(ov1), 1);
        chk("k1_out_data", i, int'(od1), k1_max[k1_sel[i-1]]);
        chk("k1_out_rank", i, int'(orank1), 0);
        chk("k1_out_last", i, int'(ol1), 1);
        chk("k1_out_sign", i, int'(os1), int'(k1_sg[k1_sel[i-1]]));
      end
    end
    @(negedge clk);
    #1;
    chk("k1_drain_valid", 5, int'(ov1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
